logic_unit_arbiter: RTL

Two-port arbiter and sequencer for one shared 32-bit logic/arithmetic unit (AND, OR, XOR, ADD) in the ALU datapath. It sits between two requesting masters and the single operation unit. It accepts one operand pair at a time through valid/ready handshakes and grants round-robin when both masters request. It computes and registers the result, then holds it on the winning port's response channel until that master accepts it.

---
 rtl/logic_unit_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Purpose:
//   Two-port arbiter/sequencer in front of one shared logic/arithmetic unit
//   (AND, OR, XOR, ADD). It takes one operand pair at a time, grants
//   round-robin under contention, computes and registers the result, then
//   holds it on the winning port's response channel until it is accepted.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   reqN_valid / reqN_ready    request handshake, N = 0,1
//   reqN_op                    00 AND, 01 OR, 10 XOR, 11 ADD (mod 2^WIDTH)
//   reqN_a, reqN_b             operands
//   rspN_valid / rspN_ready    response handshake
//   rspN_y                     result (y_q, shared by both ports)
//   busy                       high whenever the FSM is not IDLE
//   rspN_zero                  result-is-zero flag (optional)
//
// Optional feature:
//   LOGIC_ARB_ZERO_FLAG_EN     adds the registered zero flag and the
//                              rsp0_zero / rsp1_zero ports.
// ---------------------------------------------------------------------------
module logic_unit_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,

    output logic             busy
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    output logic             rsp0_zero,
    output logic             rsp1_zero
`endif
);

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    state_t                     r_state, w_state_nxt;
    req_t   [NUM_PORTS-1:0]     w_req;
    req_t                       r_req;
    logic   [NUM_PORTS-1:0]     w_vld;
    logic   [NUM_PORTS-1:0]     w_grant;
    logic   [NUM_PORTS-1:0]     w_rsp_rdy;
    logic   [NUM_PORTS-1:0]     w_rsp_vld;
    logic                       w_sel;
    logic                       w_accept;
    logic                       w_rsp_done;
    logic                       r_port;
    logic                       r_last_grant;
    logic   [WIDTH-1:0]         r_y;
    logic   [WIDTH-1:0]         w_result;

    // Gather the per-port inputs into arrays so the rest is port-indexed.
    assign w_vld     = {req1_valid, req0_valid};
    assign w_rsp_rdy = {rsp1_ready, rsp0_ready};
    assign w_req[0]  = {req0_op, req0_a, req0_b};
    assign w_req[1]  = {req1_op, req1_a, req1_b};

    // Round-robin grant: a lone requester always wins; on contention the
    // port that was not served last wins. r_last_grant = 1 means port 1 was
    // served last, so port 0 takes the first contention after reset.
    assign w_grant[0] = w_vld[0] & (~w_vld[1] | r_last_grant);
    assign w_grant[1] = w_vld[1] & (~w_vld[0] | ~r_last_grant);
    assign w_sel      = w_grant[1];

    assign w_accept   = (r_state == IDLE) & (|w_grant);
    assign req0_ready = (r_state == IDLE) & w_grant[0];
    assign req1_ready = (r_state == IDLE) & w_grant[1];

    assign w_rsp_done = (r_state == RESP) & w_rsp_rdy[r_port];
    assign busy       = (r_state != IDLE);

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)   w_state_nxt = EXEC;
            EXEC:                    w_state_nxt = RESP;
            RESP:    if (w_rsp_done) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // Operation unit, fed only from the latched request so operand changes
    // on the request ports after acceptance cannot leak into the result.
    always_comb begin
        w_result = '0;
        case (r_req.op)
            2'b00:   w_result = r_req.a & r_req.b;
            2'b01:   w_result = r_req.a | r_req.b;
            2'b10:   w_result = r_req.a ^ r_req.b;
            default: w_result = r_req.a + r_req.b;  // carry-out dropped
        endcase
    end

    // Request latch, arbitration history and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= '0;
            r_port       <= 1'b0;
            r_last_grant <= 1'b1;
            r_y          <= '0;
        end else begin
            if (w_accept) begin
                r_req        <= w_req[w_sel];
                r_port       <= w_sel;
                r_last_grant <= w_sel;
            end
            if (r_state == EXEC) begin
                r_y <= w_result;
            end
        end
    end

    // Response valid goes only to the port that owns the operation.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        assign w_rsp_vld[p] = (r_state == RESP) & (r_port == 1'(p));
    end

    assign rsp0_valid = w_rsp_vld[0];
    assign rsp1_valid = w_rsp_vld[1];
    assign rsp0_y     = r_y;
    assign rsp1_y     = r_y;

`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic r_zero;

    // Captured with the result so it is stable for the whole response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero <= 1'b1;
        end else if (r_state == EXEC) begin
            r_zero <= (w_result == '0);
        end
    end

    assign rsp0_zero = r_zero;
    assign rsp1_zero = r_zero;
`endif

endmodule
